// File: rtl/answer_serializer.sv
// Turns a 32-bit calculator result into keypad digit tokens, most significant digit first.
// An optional leading minus token precedes negative values when SIGNED is set.
module answer_serializer #(
    parameter bit         SIGNED      = 1'b1,
    parameter logic [3:0] MINUS_TOKEN = 4'hB
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] number,
    input  logic        token_ready,
    output logic [3:0]  token,
    output logic        token_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, DIVIDE, EMIT_SIGN, EMIT, FINISH} state_t;

    state_t      state_q;
    logic [31:0] mag_q;
    logic [3:0]  rem_q;
    logic [4:0]  bitCount_q;
    logic [3:0]  digitStore_q [10];
    logic [3:0]  digitCount_q;
    logic        negative_q;
    logic [3:0]  token_q;
    logic        tokenValid_q;
    logic        busy_q;
    logic        done_q;

    logic [4:0]  trial_d;
    logic        quotBit_d;
    logic [3:0]  rem_d;
    logic [31:0] mag_d;
    logic [3:0]  topDigit_d;
    logic [3:0]  nextDigit_d;

    // One restoring-division step: the quotient bit shifts into the magnitude
    // register, so after 32 steps it holds the quotient and rem_q the remainder.
    always_comb begin
        trial_d     = {rem_q, mag_q[31]};
        quotBit_d   = (trial_d >= 5'd10);
        rem_d       = quotBit_d ? 4'(trial_d - 5'd10) : trial_d[3:0];
        mag_d       = {mag_q[30:0], quotBit_d};
        topDigit_d  = digitStore_q[digitCount_q - 4'd1];
        nextDigit_d = digitStore_q[digitCount_q - 4'd2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mag_q        <= '0;
            rem_q        <= '0;
            bitCount_q   <= '0;
            digitStore_q <= '{default: '0};
            digitCount_q <= '0;
            negative_q   <= 1'b0;
            token_q      <= '0;
            tokenValid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        negative_q   <= SIGNED && number[31];
                        mag_q        <= (SIGNED && number[31]) ? 32'd0 - number : number;
                        rem_q        <= '0;
                        bitCount_q   <= '0;
                        digitCount_q <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    mag_q      <= mag_d;
                    rem_q      <= rem_d;
                    bitCount_q <= bitCount_q + 5'd1;
                    if (bitCount_q == 5'd31) begin
                        // A digit is complete; the last one pushed is the MSD,
                        // so it can be presented directly when the quotient hits 0.
                        digitStore_q[digitCount_q] <= rem_d;
                        digitCount_q               <= digitCount_q + 4'd1;
                        rem_q                      <= '0;
                        if (mag_d == 32'd0) begin
                            tokenValid_q <= 1'b1;
                            if (negative_q) begin
                                token_q <= MINUS_TOKEN;
                                state_q <= EMIT_SIGN;
                            end else begin
                                token_q <= rem_d;
                                state_q <= EMIT;
                            end
                        end
                    end
                end
                EMIT_SIGN: begin
                    if (token_ready) begin
                        token_q <= topDigit_d;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (token_ready) begin
                        digitCount_q <= digitCount_q - 4'd1;
                        if (digitCount_q == 4'd1) begin
                            token_q      <= '0;
                            tokenValid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            state_q      <= FINISH;
                        end else begin
                            token_q <= nextDigit_d;
                        end
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign token       = token_q;
    assign token_valid = tokenValid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
